// File: rtl/pnr_sequencer.sv
// Photon-number-resolving sequencer.
// Waits for an armed trigger edge, tracks the signed peak of the ADC stream over
// a window of N samples, classifies the peak against seven thresholds, then
// enforces a dead time before re-arming.
// Ports:
//   clk_i, rstn_i                 clock, synchronous active-low reset
//   adc_dat_i                     signed ADC sample
//   adc_photon_threshold_1..7     signed class thresholds (sampled live)
//   arm_i, abort_i, trig_i        control: arm level, abort level, trigger
//   window_len_i, holdoff_i       window length (0 means 1), dead time in cycles
//   photon_num_o, photon_vld_o    classification result and its one-cycle strobe
//   peak_o, order_err_o           peak of last window, threshold ordering flag
//   state_o                       FSM state (IDLE=0 ARMED=1 WINDOW=2 CLASSIFY=3 HOLDOFF=4)
//   event_cnt_o, miss_cnt_o       saturating event and missed-trigger counters
module pnr_sequencer (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic signed [13:0]  adc_dat_i,
    input  logic signed [13:0]  adc_photon_threshold_1,
    input  logic signed [13:0]  adc_photon_threshold_2,
    input  logic signed [13:0]  adc_photon_threshold_3,
    input  logic signed [13:0]  adc_photon_threshold_4,
    input  logic signed [13:0]  adc_photon_threshold_5,
    input  logic signed [13:0]  adc_photon_threshold_6,
    input  logic signed [13:0]  adc_photon_threshold_7,
    input  logic                arm_i,
    input  logic                abort_i,
    input  logic                trig_i,
    input  logic [15:0]         window_len_i,
    input  logic [15:0]         holdoff_i,
    output logic [2:0]          photon_num_o,
    output logic                photon_vld_o,
    output logic signed [13:0]  peak_o,
    output logic [2:0]          state_o,
    output logic                order_err_o,
    output logic [31:0]         event_cnt_o,
    output logic [15:0]         miss_cnt_o
);

    localparam int unsigned DW = 14;
    localparam int unsigned LW = 16;
    localparam int unsigned EW = 32;
    localparam int unsigned MW = 16;
    localparam int unsigned SW = 3;
    localparam int unsigned NT = 7;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_WINDOW   = 3'd2;
    localparam logic [2:0] ST_CLASSIFY = 3'd3;
    localparam logic [2:0] ST_HOLDOFF  = 3'd4;

    logic [SW-1:0]        state_q,     state_d;
    logic                 trig_prev_q;
    logic signed [DW-1:0] peak_q,      peak_d;
    logic [LW-1:0]        cnt_q,       cnt_d;
    logic [LW-1:0]        win_len_q,   win_len_d;
    logic [LW-1:0]        hold_cnt_q,  hold_cnt_d;
    logic [2:0]           photon_num_q, photon_num_d;
    logic                 photon_vld_q, photon_vld_d;
    logic signed [DW-1:0] peak_out_q,  peak_out_d;
    logic                 order_err_q, order_err_d;
    logic [EW-1:0]        event_cnt_q, event_cnt_d;
    logic [MW-1:0]        miss_cnt_q,  miss_cnt_d;

    logic                 trig_edge_c;
    logic signed [DW-1:0] thr_c [NT];
    logic [2:0]           class_num_c;
    logic                 order_err_c;

    assign trig_edge_c = trig_i & ~trig_prev_q;

    // Classification: count thresholds at or below the peak; flag any descending pair.
    always_comb begin
        thr_c[0] = adc_photon_threshold_1;
        thr_c[1] = adc_photon_threshold_2;
        thr_c[2] = adc_photon_threshold_3;
        thr_c[3] = adc_photon_threshold_4;
        thr_c[4] = adc_photon_threshold_5;
        thr_c[5] = adc_photon_threshold_6;
        thr_c[6] = adc_photon_threshold_7;
        class_num_c = 3'd0;
        order_err_c = 1'b0;
        for (int k = 0; k < NT; k++) begin
            if (peak_q >= thr_c[k]) class_num_c = class_num_c + 3'd1;
        end
        for (int k = 0; k < NT - 1; k++) begin
            if (thr_c[k] > thr_c[k+1]) order_err_c = 1'b1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        peak_d       = peak_q;
        cnt_d        = cnt_q;
        win_len_d    = win_len_q;
        hold_cnt_d   = hold_cnt_q;
        photon_num_d = photon_num_q;
        photon_vld_d = 1'b0;
        peak_out_d   = peak_out_q;
        order_err_d  = order_err_q;
        event_cnt_d  = event_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        // Edges arriving while busy are dropped but counted, abort or not.
        if (trig_edge_c && (state_q == ST_WINDOW || state_q == ST_CLASSIFY ||
                            state_q == ST_HOLDOFF) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + MW'(1);
        end

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_edge_c) begin
                        state_d   = ST_WINDOW;
                        peak_d    = adc_dat_i;
                        cnt_d     = LW'(1);
                        win_len_d = (window_len_i == '0) ? LW'(1) : window_len_i;
                    end else if (!arm_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WINDOW: begin
                    if (cnt_q == win_len_q) begin
                        state_d = ST_CLASSIFY;
                    end else begin
                        if (adc_dat_i > peak_q) peak_d = adc_dat_i;
                        cnt_d = cnt_q + LW'(1);
                    end
                end
                ST_CLASSIFY: begin
                    state_d      = ST_HOLDOFF;
                    photon_num_d = class_num_c;
                    photon_vld_d = 1'b1;
                    peak_out_d   = peak_q;
                    order_err_d  = order_err_c;
                    hold_cnt_d   = holdoff_i;
                    if (event_cnt_q != '1) event_cnt_d = event_cnt_q + EW'(1);
                end
                ST_HOLDOFF: begin
                    // Loaded at entry; a value of 0 or 1 leaves after one cycle.
                    if (hold_cnt_q <= LW'(1)) begin
                        state_d = arm_i ? ST_ARMED : ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - LW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            trig_prev_q  <= 1'b0;
            peak_q       <= '0;
            cnt_q        <= '0;
            win_len_q    <= '0;
            hold_cnt_q   <= '0;
            photon_num_q <= '0;
            photon_vld_q <= 1'b0;
            peak_out_q   <= '0;
            order_err_q  <= 1'b0;
            event_cnt_q  <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            trig_prev_q  <= trig_i;
            peak_q       <= peak_d;
            cnt_q        <= cnt_d;
            win_len_q    <= win_len_d;
            hold_cnt_q   <= hold_cnt_d;
            photon_num_q <= photon_num_d;
            photon_vld_q <= photon_vld_d;
            peak_out_q   <= peak_out_d;
            order_err_q  <= order_err_d;
            event_cnt_q  <= event_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign photon_num_o = photon_num_q;
    assign photon_vld_o = photon_vld_q;
    assign peak_o       = peak_out_q;
    assign state_o      = state_q;
    assign order_err_o  = order_err_q;
    assign event_cnt_o  = event_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_pnr_sequencer.sv
// Directed testbench for pnr_sequencer: inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_pnr_sequencer;

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic signed [13:0] adc_dat_i;
    logic signed [13:0] thr1, thr2, thr3, thr4, thr5, thr6, thr7;
    logic               arm_i, abort_i, trig_i;
    logic [15:0]        window_len_i, holdoff_i;
    logic [2:0]         photon_num_o;
    logic               photon_vld_o;
    logic signed [13:0] peak_o;
    logic [2:0]         state_o;
    logic               order_err_o;
    logic [31:0]        event_cnt_o;
    logic [15:0]        miss_cnt_o;

    int n_run  = 0;
    int n_fail = 0;
    int vcnt;
    int vld_at;

    always #5 clk_i = ~clk_i;

    pnr_sequencer dut (
        .clk_i                  (clk_i),
        .rstn_i                 (rstn_i),
        .adc_dat_i              (adc_dat_i),
        .adc_photon_threshold_1 (thr1),
        .adc_photon_threshold_2 (thr2),
        .adc_photon_threshold_3 (thr3),
        .adc_photon_threshold_4 (thr4),
        .adc_photon_threshold_5 (thr5),
        .adc_photon_threshold_6 (thr6),
        .adc_photon_threshold_7 (thr7),
        .arm_i                  (arm_i),
        .abort_i                (abort_i),
        .trig_i                 (trig_i),
        .window_len_i           (window_len_i),
        .holdoff_i              (holdoff_i),
        .photon_num_o           (photon_num_o),
        .photon_vld_o           (photon_vld_o),
        .peak_o                 (peak_o),
        .state_o                (state_o),
        .order_err_o            (order_err_o),
        .event_cnt_o            (event_cnt_o),
        .miss_cnt_o             (miss_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_thr(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g);
        thr1 = 14'(a); thr2 = 14'(b); thr3 = 14'(c); thr4 = 14'(d);
        thr5 = 14'(e); thr6 = 14'(f); thr7 = 14'(g);
    endtask

    // N=1 event: trigger edge T, CLASSIFY after T+1, strobe visible after T+2.
    task automatic one_shot(input int s);
        trig_i = 1'b1; adc_dat_i = 14'(s);
        tick();
        trig_i = 1'b0; adc_dat_i = 14'(0);
        tick();
        tick();
    endtask

    initial begin
        rstn_i = 1'b0; arm_i = 1'b0; abort_i = 1'b0; trig_i = 1'b0;
        adc_dat_i = '0; window_len_i = 16'd4; holdoff_i = 16'd0;
        set_thr(100, 200, 300, 400, 500, 600, 700);
        tick(); tick();
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_vld",   32'(photon_vld_o), 32'd0);
        check_eq("rst_evt",   event_cnt_o, 32'd0);
        check_eq("rst_miss",  32'(miss_cnt_o), 32'd0);

        rstn_i = 1'b1; arm_i = 1'b1;
        tick();
        check_eq("armed", 32'(state_o), 32'd1);

        // Four-sample window, peak 350; mid-window length change must not matter.
        trig_i = 1'b1; adc_dat_i = 14'(50);
        tick();
        check_eq("win_entry", 32'(state_o), 32'd2);
        trig_i = 1'b0; window_len_i = 16'd1; adc_dat_i = 14'(350);
        tick();
        adc_dat_i = 14'(120);
        tick();
        adc_dat_i = 14'(80);
        tick();
        check_eq("win_T3_state", 32'(state_o), 32'd2);
        adc_dat_i = 14'(9000 - 8000);
        tick();
        check_eq("cls_state", 32'(state_o), 32'd3);
        check_eq("cls_vld0",  32'(photon_vld_o), 32'd0);
        tick();
        check_eq("n4_vld",  32'(photon_vld_o), 32'd1);
        check_eq("n4_num",  32'(photon_num_o), 32'd3);
        check_eq("n4_peak", 32'(peak_o), 32'(350));
        check_eq("n4_evt",  event_cnt_o, 32'd1);
        check_eq("n4_hold", 32'(state_o), 32'd4);
        tick();
        check_eq("n4_vld_off", 32'(photon_vld_o), 32'd0);
        check_eq("n4_rearm",   32'(state_o), 32'd1);

        // Single-sample extremes and the equality boundary.
        one_shot(-8000);
        check_eq("neg_vld",  32'(photon_vld_o), 32'd1);
        check_eq("neg_num",  32'(photon_num_o), 32'd0);
        check_eq("neg_peak", 32'(peak_o), 32'(-8000));
        tick();
        one_shot(8191);
        check_eq("max_num",  32'(photon_num_o), 32'd7);
        check_eq("max_peak", 32'(peak_o), 32'(8191));
        check_eq("max_evt",  event_cnt_o, 32'd3);
        tick();

        set_thr(100, 300, 200, 400, 500, 600, 700);
        one_shot(250);
        check_eq("ord_err", 32'(order_err_o), 32'd1);
        check_eq("ord_num", 32'(photon_num_o), 32'd2);
        tick();
        set_thr(100, 200, 300, 400, 500, 600, 700);
        one_shot(700);
        check_eq("eq700_num", 32'(photon_num_o), 32'd7);
        check_eq("eq700_ord", 32'(order_err_o), 32'd0);
        tick();
        one_shot(699);
        check_eq("b699_num", 32'(photon_num_o), 32'd6);
        check_eq("b699_evt", event_cnt_o, 32'd6);
        tick();

        // Holdoff 10 with three busy-time trigger edges, arm held.
        holdoff_i = 16'd10; window_len_i = 16'd4;
        trig_i = 1'b1; adc_dat_i = 14'(150);
        tick();
        vcnt = 0; vld_at = -1;
        for (int i = 1; i <= 16; i++) begin
            trig_i = (i == 2 || i == 6 || i == 8);
            adc_dat_i = 14'(100);
            tick();
            if (photon_vld_o) begin vcnt++; vld_at = i; end
            if (i == 14) check_eq("ho_still", 32'(state_o), 32'd4);
            if (i == 15) check_eq("ho_armed", 32'(state_o), 32'd1);
        end
        trig_i = 1'b0;
        check_eq("ho_pulses", 32'(vcnt), 32'd1);
        check_eq("ho_vld_at", 32'(vld_at), 32'd5);
        check_eq("ho_num",    32'(photon_num_o), 32'd1);
        check_eq("ho_miss",   32'(miss_cnt_o), 32'd3);
        check_eq("ho_evt",    event_cnt_o, 32'd7);

        // Same with arm dropped: must end in IDLE.
        trig_i = 1'b1; adc_dat_i = 14'(150);
        tick();
        trig_i = 1'b0; arm_i = 1'b0;
        vcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (photon_vld_o) vcnt++;
            if (i == 15) check_eq("ho_idle", 32'(state_o), 32'd0);
        end
        check_eq("ho2_pulses", 32'(vcnt), 32'd1);
        check_eq("ho2_miss",   32'(miss_cnt_o), 32'd3);
        arm_i = 1'b1; holdoff_i = 16'd0;
        tick();
        check_eq("rearm", 32'(state_o), 32'd1);

        // Abort mid-WINDOW.
        window_len_i = 16'd4;
        trig_i = 1'b1; adc_dat_i = 14'(500);
        tick();
        trig_i = 1'b0; abort_i = 1'b1;
        tick();
        check_eq("abw_state", 32'(state_o), 32'd0);
        abort_i = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (photon_vld_o) vcnt++;
        end
        check_eq("abw_pulses", 32'(vcnt), 32'd0);
        check_eq("abw_evt",    event_cnt_o, 32'd8);
        check_eq("abw_rearm",  32'(state_o), 32'd1);

        // Abort in CLASSIFY.
        window_len_i = 16'd1;
        trig_i = 1'b1; adc_dat_i = 14'(500);
        tick();
        trig_i = 1'b0;
        tick();
        check_eq("abc_cls", 32'(state_o), 32'd3);
        abort_i = 1'b1;
        tick();
        check_eq("abc_state", 32'(state_o), 32'd0);
        abort_i = 1'b0;
        vcnt = (photon_vld_o) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (photon_vld_o) vcnt++;
        end
        check_eq("abc_pulses", 32'(vcnt), 32'd0);
        check_eq("abc_evt",    event_cnt_o, 32'd8);

        // Reset mid-window clears everything.
        window_len_i = 16'd4;
        trig_i = 1'b1; adc_dat_i = 14'(500);
        tick();
        trig_i = 1'b0;
        tick();
        rstn_i = 1'b0;
        tick();
        check_eq("rw_state", 32'(state_o), 32'd0);
        check_eq("rw_vld",   32'(photon_vld_o), 32'd0);
        check_eq("rw_num",   32'(photon_num_o), 32'd0);
        check_eq("rw_peak",  32'(peak_o), 32'd0);
        check_eq("rw_evt",   event_cnt_o, 32'd0);
        check_eq("rw_miss",  32'(miss_cnt_o), 32'd0);
        rstn_i = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (photon_vld_o) vcnt++;
        end
        check_eq("rw_pulses", 32'(vcnt), 32'd0);
        check_eq("rw_armed",  32'(state_o), 32'd1);

        // window_len 0 acts as 1; trigger held high yields one event.
        window_len_i = 16'd0;
        trig_i = 1'b1; adc_dat_i = 14'(450);
        tick();
        adc_dat_i = 14'(8000);
        vcnt = 0; vld_at = -1;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (photon_vld_o) begin vcnt++; vld_at = i; end
        end
        trig_i = 1'b0;
        tick();
        check_eq("w0_pulses", 32'(vcnt), 32'd1);
        check_eq("w0_vld_at", 32'(vld_at), 32'd2);
        check_eq("w0_num",    32'(photon_num_o), 32'd4);
        check_eq("w0_peak",   32'(peak_o), 32'(450));
        check_eq("w0_evt",    event_cnt_o, 32'd1);
        check_eq("w0_miss",   32'(miss_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
